gshare_pht_reader: RTL

- Prediction-side consumer of the 8-bit global history register.
- Hashes the fetch PC with the GHR value into a pattern history table (PHT) of 2-bit saturating counters and returns a registered taken/not-taken prediction.
- Tracks in-flight predictions in order; at branch resolution it trains the PHT and emits the update/taken pulse that drives the history register's update/taken inputs.
- Sits between fetch (lookup), execute (resolve) and the GHR.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_inflight_fifo.sv | 55 +++++
 rtl/gshare_pht_reader.sv | 93 +++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: history width, 2-bit saturating counter
// encoding and the counter training function.
package bp_pkg;

  localparam int GHR_W = 8;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'd0;
  localparam cnt_t CNT_WNT = 2'd1;
  localparam cnt_t CNT_WT  = 2'd2;
  localparam cnt_t CNT_ST  = 2'd3;

  // Move one step toward the observed outcome, saturating at both ends.
  function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
    if (taken) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of in-flight predictions with occupancy count.
// Pushes when full and pops when empty are ignored.
module bp_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gshare_pht_reader.sv
// Gshare prediction: PC xor global history indexes a table of 2-bit counters;
// resolved branches train the table and pulse the history register update.
module gshare_pht_reader
  import bp_pkg::cnt_t, bp_pkg::CNT_WNT, bp_pkg::sat_update;
#(
  parameter int   GHR_W    = bp_pkg::GHR_W,
  parameter int   PC_W     = 32,
  parameter int   Q_DEPTH  = 4,
  parameter cnt_t CNT_INIT = CNT_WNT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lookup_valid,
  input  logic [PC_W-1:0]            lookup_pc,
  output logic                       lookup_ready,
  input  logic [GHR_W-1:0]           ghr,
  output logic                       pred_valid,
  output logic                       pred_taken,
  output logic [GHR_W-1:0]           pred_idx,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       ghr_update,
  output logic                       ghr_taken,
  output logic                       mispredict,
  output logic [$clog2(Q_DEPTH):0]   q_count
);

  localparam int PHT_N = 2 ** GHR_W;

  cnt_t             pht [PHT_N];
  logic [GHR_W-1:0] lookup_idx;
  logic [GHR_W-1:0] head_idx;
  logic             head_pred;
  logic [GHR_W:0]   head_data;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             unused_pc_bits;

  // Word-aligned PC bits only; the low two bits and the upper bits do not hash.
  assign lookup_idx     = lookup_pc[GHR_W+1:2] ^ ghr;
  assign unused_pc_bits = ^{lookup_pc[PC_W-1:GHR_W+2], lookup_pc[1:0]};

  assign lookup_ready = !full;
  assign push         = lookup_valid && !full;
  assign pop          = resolve_valid && !empty;
  assign {head_idx, head_pred} = head_data;

  bp_inflight_fifo #(
    .DEPTH (Q_DEPTH),
    .W     (GHR_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({lookup_idx, pht[lookup_idx][1]}),
    .pop   (pop),
    .rdata (head_data),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  // Counters must restart weakly not-taken, so the whole table is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= CNT_INIT;
    end else if (pop) begin
      pht[head_idx] <= sat_update(pht[head_idx], resolve_taken);
    end
  end

  // A lookup reads the table before this edge's training write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
      ghr_update <= 1'b0;
      ghr_taken  <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      pred_valid <= push;
      pred_taken <= push && pht[lookup_idx][1];
      if (push) pred_idx <= lookup_idx;
      ghr_update <= pop;
      ghr_taken  <= pop && resolve_taken;
      mispredict <= pop && (resolve_taken != head_pred);
    end
  end

endmodule
